// File: rtl/instr_mem_responder.sv
// Instruction-memory responder: serves word-aligned fetches from a byte store
// after a fixed access latency, stalling the CPU through BUSYWAIT.
module instr_mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  READ,
    input  logic [31:0]           ADDRESS,
    output logic [31:0]           READDATA,
    output logic                  BUSYWAIT,
    output logic                  ERROR,
    input  logic                  LOAD_EN,
    input  logic [ADDR_WIDTH-1:0] LOAD_ADDR,
    input  logic [7:0]            LOAD_DATA
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                state, state_nxt;
    logic [3:0]            cnt, cnt_nxt;
    logic [ADDR_WIDTH-3:0] word_lat;
    logic                  accept, misalign, load_word;
    logic [31:0]           word;
    logic [7:0]            mem [0:(2**ADDR_WIDTH)-1];

    logic unused_addr_bits;
    assign unused_addr_bits = ^ADDRESS[31:ADDR_WIDTH];

    // Store is never cleared by reset; the load port runs regardless of the FSM.
    always_ff @(posedge CLK) begin
        if (LOAD_EN)
            mem[LOAD_ADDR] <= LOAD_DATA;
        if (accept)
            word_lat <= ADDRESS[ADDR_WIDTH-1:2];
    end

    // Combinational read of the latched word; sampling it with <= gives read-before-write.
    always_comb begin
        word = {mem[{word_lat, 2'd3}], mem[{word_lat, 2'd2}],
                mem[{word_lat, 2'd1}], mem[{word_lat, 2'd0}]};
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        misalign  = 1'b0;
        load_word = 1'b0;
        case (state)
            IDLE: begin
                if (READ) begin
                    if (ADDRESS[1:0] == 2'b00) begin
                        accept    = 1'b1;
                        cnt_nxt   = 4'(LATENCY - 1);
                        state_nxt = BUSY;
                    end else begin
                        misalign = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!READ) begin
                    state_nxt = IDLE;
                end else if (cnt == 4'd0) begin
                    load_word = 1'b1;
                    state_nxt = DONE;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // No request can be accepted while reset is held, so stall is suppressed too.
    assign BUSYWAIT = !RESET && (accept || (state == BUSY));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            READDATA <= 32'd0;
            ERROR    <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (load_word)
                READDATA <= word;
            if (misalign)
                ERROR <= 1'b1;
        end
    end

endmodule
